ay8913_psg: RTL and testbench

//  AY-3-8913-compatible programmable sound generator as a TinyTapeout user tile.
//  - 3 square-wave tone channels, 1 noise source, 1 envelope generator, 16-register map.
//  - Registers are written over an 8-bit bus with BDIR/BC1 control.
//  - The three channel levels are summed into one 8-bit unsigned audio sample on uo_out.

---
 rtl/ay8913_pkg.sv | 43 ++++
 rtl/ay8913_tone.sv | 31 +++
 rtl/ay8913_psg.sv | 181 ++++++++++++++++++
 tb/tb_ay8913_psg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ay8913_pkg.sv
// Shared constants for the AY-3-8913 compatible sound generator: register map,
// envelope shape bits, log volume table, noise seed and bus decode encoding.
package ay8913_pkg;

    localparam logic [3:0] R_TONE_A_FINE   = 4'd0;
    localparam logic [3:0] R_TONE_A_COARSE = 4'd1;
    localparam logic [3:0] R_TONE_B_FINE   = 4'd2;
    localparam logic [3:0] R_TONE_B_COARSE = 4'd3;
    localparam logic [3:0] R_TONE_C_FINE   = 4'd4;
    localparam logic [3:0] R_TONE_C_COARSE = 4'd5;
    localparam logic [3:0] R_NOISE_PERIOD  = 4'd6;
    localparam logic [3:0] R_MIXER         = 4'd7;
    localparam logic [3:0] R_AMP_A         = 4'd8;
    localparam logic [3:0] R_AMP_B         = 4'd9;
    localparam logic [3:0] R_AMP_C         = 4'd10;
    localparam logic [3:0] R_ENV_FINE      = 4'd11;
    localparam logic [3:0] R_ENV_COARSE    = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE     = 4'd13;

    // R14/R15 are the I/O ports of the original chip; they are never writable here and read as 0.
    localparam int NUM_RW_REGS = 14;

    localparam int SH_HOLD = 0;
    localparam int SH_ALT  = 1;
    localparam int SH_ATT  = 2;
    localparam int SH_CONT = 3;

    localparam logic [15:0][7:0] LOG_VOL = {
        8'd63, 8'd44, 8'd30, 8'd22, 8'd16, 8'd12, 8'd9, 8'd7,
        8'd5,  8'd4,  8'd3,  8'd2,  8'd2,  8'd1,  8'd1, 8'd0
    };

    localparam logic [16:0] LFSR_RESET = 17'h1;

    // Encoding of {BDIR, BC1}.
    typedef enum logic [1:0] {
        BUS_IDLE     = 2'b00,
        BUS_IDLE_BC1 = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_LATCH    = 2'b11
    } bus_op_e;

endpackage

// File: rtl/ay8913_tone.sv
// One square-wave tone channel: 12-bit period counter advancing on the prescaler
// strobe, toggling its output flop at terminal count (period 0 behaves as 1).
module ay8913_tone (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strobe,
    input  logic [11:0] period,
    output logic        tone
);

    logic [11:0] cnt;
    logic [11:0] last;

    assign last = (period == 12'd0) ? 12'd0 : period - 12'd1;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (strobe) begin
            if (cnt >= last) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + 12'd1;
            end
        end
    end

endmodule

// File: rtl/ay8913_psg.sv
// AY-3-8913 compatible PSG tile: bus decode, register file, noise, envelope and mixer.
// Build option LOG_VOLUME_EN selects the logarithmic volume table instead of linear v*4.
module ay8913_psg
    import ay8913_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] TONE_FINE   [3] = '{R_TONE_A_FINE, R_TONE_B_FINE, R_TONE_C_FINE};
    localparam logic [3:0] TONE_COARSE [3] = '{R_TONE_A_COARSE, R_TONE_B_COARSE, R_TONE_C_COARSE};
    localparam logic [3:0] AMP_REG     [3] = '{R_AMP_A, R_AMP_B, R_AMP_C};

    bus_op_e    bus_op;
    logic [7:0] addr;
    logic [7:0] regs [NUM_RW_REGS];
    logic       wr_en;
    logic       env_restart;

    assign bus_op      = bus_op_e'(uio_in[1:0]);
    assign wr_en       = (bus_op == BUS_WRITE) && (addr[7:4] == 4'd0) && (addr[3:0] <= R_ENV_SHAPE);
    assign env_restart = wr_en && (addr[3:0] == R_ENV_SHAPE);

    // NOTE: the register file is tiny and must read as zero after reset, so it is reset like plain flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
        end else begin
            if (bus_op == BUS_LATCH) addr <= ui_in;
            if (wr_en) regs[addr[3:0]] <= ui_in;
        end
    end

    logic [2:0] pre;
    logic       half;
    logic       s;
    logic       s2;

    assign s  = (pre == 3'd7);
    assign s2 = s & half;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre  <= '0;
            half <= 1'b0;
        end else begin
            pre <= pre + 3'd1;
            if (s) half <= ~half;
        end
    end

    logic [2:0] tone;

    for (genvar ch = 0; ch < 3; ch++) begin : g_tone
        ay8913_tone u_tone (
            .clk    (clk),
            .rst_n  (rst_n),
            .strobe (s),
            .period ({regs[TONE_COARSE[ch]][3:0], regs[TONE_FINE[ch]]}),
            .tone   (tone[ch])
        );
    end

    logic [4:0]  noise_cnt;
    logic [4:0]  noise_last;
    logic [16:0] lfsr;

    assign noise_last = (regs[R_NOISE_PERIOD][4:0] == 5'd0) ? 5'd0 : regs[R_NOISE_PERIOD][4:0] - 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            noise_cnt <= '0;
            lfsr      <= LFSR_RESET;
        end else if (s2) begin
            if (noise_cnt >= noise_last) begin
                noise_cnt <= '0;
                lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
            end else begin
                noise_cnt <= noise_cnt + 5'd1;
            end
        end
    end

    logic [15:0] env_period;
    logic [15:0] env_last;
    logic [15:0] env_cnt;
    logic [3:0]  env_step;
    logic        env_hold;
    logic        env_flip;
    logic [3:0]  shape;
    logic [3:0]  env_level;

    assign env_period = {regs[R_ENV_COARSE], regs[R_ENV_FINE]};
    assign env_last   = (env_period == 16'd0) ? 16'd0 : env_period - 16'd1;
    assign shape      = regs[R_ENV_SHAPE][3:0];

    always_ff @(posedge clk) begin
        if (!rst_n || env_restart) begin
            env_cnt  <= '0;
            env_step <= '0;
            env_hold <= 1'b0;
            env_flip <= 1'b0;
        end else if (s2) begin
            if (env_cnt >= env_last) begin
                env_cnt <= '0;
                if (!env_hold) begin
                    if (env_step == 4'd15) begin
                        if (!shape[SH_CONT] || shape[SH_HOLD]) begin
                            env_hold <= 1'b1;
                        end else begin
                            env_step <= '0;
                            env_flip <= ~env_flip;
                        end
                    end else begin
                        env_step <= env_step + 4'd1;
                    end
                end
            end else begin
                env_cnt <= env_cnt + 16'd1;
            end
        end
    end

    // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        env_level = shape[SH_ATT] ? env_step : ~env_step;
        if (shape[SH_ALT] && !shape[SH_HOLD] && env_flip) env_level = ~env_level;
        if (env_hold) begin
            env_level = (shape[SH_CONT] && (shape[SH_ATT] != shape[SH_ALT])) ? 4'd15 : 4'd0;
        end
    end

`ifdef LOG_VOLUME_EN
    function automatic logic [7:0] vol_map(input logic [3:0] v);
        return LOG_VOL[v];
    endfunction
`else
    function automatic logic [7:0] vol_map(input logic [3:0] v);
        return {2'b00, v, 2'b00};
    endfunction

    logic unused_log_vol;
    assign unused_log_vol = &{1'b0, LOG_VOL};
`endif

    logic [7:0] mix_sum;

    always_comb begin
        logic [3:0] vol;
        logic       on;
        mix_sum = '0;
        for (int ch = 0; ch < 3; ch++) begin
            vol = regs[AMP_REG[ch]][4] ? env_level : regs[AMP_REG[ch]][3:0];
            on  = (tone[ch] | regs[R_MIXER][ch]) & (lfsr[0] | regs[R_MIXER][3 + ch]);
            if (on) mix_sum = mix_sum + vol_map(vol);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) uo_out <= '0;
        else        uo_out <= mix_sum;
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2],
                         regs[R_TONE_A_COARSE][7:4], regs[R_TONE_B_COARSE][7:4],
                         regs[R_TONE_C_COARSE][7:4], regs[R_NOISE_PERIOD][7:5],
                         regs[R_MIXER][7:6], regs[R_AMP_A][7:5], regs[R_AMP_B][7:5],
                         regs[R_AMP_C][7:5], regs[R_ENV_SHAPE][7:4]};

endmodule

// File: tb/tb_ay8913_psg.sv
// Directed self-checking bench for ay8913_psg: reset, tone timing, zero period,
// envelope ramp and hold, noise LFSR sequence, and ignored out-of-range writes.
module tb_ay8913_psg;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

`ifdef LOG_VOLUME_EN
    int log_tab [16] = '{0, 1, 1, 2, 2, 3, 4, 5, 7, 9, 12, 16, 22, 30, 44, 63};
    function automatic int exp_map(input int v);
        return log_tab[v];
    endfunction
`else
    function automatic int exp_map(input int v);
        return v * 4;
    endfunction
`endif

    ay8913_psg dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        uio_in = 8'h03;
        ui_in  = a;
        @(negedge clk);
        uio_in = 8'h02;
        ui_in  = d;
        @(negedge clk);
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic wait_change(output int clocks, output bit timed_out);
        logic [7:0] start;
        start  = uo_out;
        clocks = 0;
        while (uo_out === start && clocks < 200) begin
            @(negedge clk);
            clocks++;
        end
        timed_out = (uo_out === start);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_hold_uo: got %0d expected 0", uo_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (uo_out !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_uo cycle %0d: got %0d expected 0", i, uo_out);
            end
            n_cmp++;
            if (uio_oe !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_uio_oe cycle %0d: got %0d expected 0", i, uio_oe);
            end
            n_cmp++;
            if (uio_out !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_uio_out cycle %0d: got %0d expected 0", i, uio_out);
            end
        end
    endtask

    // Syncs to the square wave on channel A, then checks 4 half-periods and their levels.
    task automatic check_square(input string name, input int half_clk);
        int         clocks;
        bit         to;
        logic [7:0] prev;
        for (int i = 0; i < 2; i++) begin
            wait_change(clocks, to);
            if (to) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_sync: no edge within 200 clk, uo_out=%0d", name, uo_out);
                return;
            end
        end
        for (int i = 0; i < 4; i++) begin
            prev = uo_out;
            wait_change(clocks, to);
            n_cmp++;
            if (to || clocks != half_clk) begin
                n_bad++;
                $display("FAIL %s_half %0d: got %0d clk expected %0d", name, i, clocks, half_clk);
            end
            n_cmp++;
            if (int'(uo_out) != ((prev == 8'd0) ? exp_map(15) : 0)) begin
                n_bad++;
                $display("FAIL %s_level %0d: got %0d after %0d", name, i, uo_out, prev);
            end
        end
    endtask

    task automatic test_tone();
        bus_write(8'd0, 8'd4);
        bus_write(8'd8, 8'd15);
        bus_write(8'd7, 8'h3E);
        check_square("tone_p4", 32);
    endtask

    task automatic test_zero_period();
        bus_write(8'd0, 8'd0);
        check_square("tone_p0", 8);
        bus_write(8'd0, 8'd1);
        check_square("tone_p1", 8);
    endtask

    task automatic test_envelope();
        int waited;
        bus_write(8'd7, 8'h3F);
        bus_write(8'd8, 8'h10);
        bus_write(8'd11, 8'd1);
        bus_write(8'd12, 8'd0);
        bus_write(8'd13, 8'h0D);
        @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'd0) begin
            n_bad++;
            $display("FAIL env_step0: got %0d expected 0", uo_out);
        end
        waited = 0;
        while (int'(uo_out) != exp_map(1) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (int'(uo_out) != exp_map(1)) begin
            n_bad++;
            $display("FAIL env_step1_timeout: got %0d expected %0d", uo_out, exp_map(1));
            return;
        end
        repeat (8) @(negedge clk);
        for (int k = 1; k < 19; k++) begin
            n_cmp++;
            if (int'(uo_out) != exp_map((k > 15) ? 15 : k)) begin
                n_bad++;
                $display("FAIL env_step %0d: got %0d expected %0d", k, uo_out, exp_map((k > 15) ? 15 : k));
            end
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_noise();
        logic [16:0] lfsr_m;
        int          expv;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_write(8'd7, 8'h37);
        bus_write(8'd6, 8'd1);
        bus_write(8'd8, 8'd15);
        lfsr_m = 17'h1;
        for (int k = 0; k < 70; k++) begin
            if (k >= 2) begin
                repeat (16 * k + 8 - cyc) @(negedge clk);
                expv = lfsr_m[0] ? exp_map(15) : 0;
                n_cmp++;
                if (int'(uo_out) != expv) begin
                    n_bad++;
                    $display("FAIL noise_step %0d: got %0d expected %0d", k, uo_out, expv);
                end
            end
            lfsr_m = {lfsr_m[0] ^ lfsr_m[3], lfsr_m[16:1]};
        end
    endtask

    task automatic test_bad_address();
        bus_write(8'd7, 8'h3F);
        bus_write(8'd8, 8'd5);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (int'(uo_out) != exp_map(5)) begin
            n_bad++;
            $display("FAIL addr_setup: got %0d expected %0d", uo_out, exp_map(5));
        end
        bus_write(8'h18, 8'hFF);
        bus_write(8'd14, 8'hFF);
        bus_write(8'd15, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (int'(uo_out) != exp_map(5)) begin
                n_bad++;
                $display("FAIL addr_ignored %0d: got %0d expected %0d", i, uo_out, exp_map(5));
            end
        end
        bus_write(8'd8, 8'd10);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (int'(uo_out) != exp_map(10)) begin
            n_bad++;
            $display("FAIL addr_valid_after: got %0d expected %0d", uo_out, exp_map(10));
        end
    endtask

    initial begin
        test_reset();
        test_tone();
        test_zero_period();
        test_envelope();
        test_noise();
        test_bad_address();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
